// File: rtl/calc_pkg.sv
// Shared constants for the calculator result formatter: modes, FSM states, sizes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

    localparam int CALC_WIDTH  = 10;
    localparam int CALC_DIGITS = 3;

    typedef enum logic [2:0] {
        MODE_ADD = 3'b000,
        MODE_SUB = 3'b001,
        MODE_MUL = 3'b010,
        MODE_DIV = 3'b011,
        MODE_CMP = 3'b100,
        MODE_AND = 3'b101,
        MODE_OR  = 3'b110,
        MODE_SHF = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CONV = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
// Latency: combinational.
// Backpressure: none.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/calc_result_formatter.sv
// Captures a calculator result, converts the mode-relevant field to sign + BCD.
// Latency: out_valid rises WIDTH+1 cycles after the accept edge.
// Backpressure: in_ready low from accept until the output handshake; outputs hold while out_ready is low.
module calc_result_formatter
    import calc_pkg::*;
#(
    parameter int WIDTH  = CALC_WIDTH,
    parameter int DIGITS = CALC_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            mode,
    input  logic [WIDTH-1:0]      op,
    input  logic [3:0]            rem,
    input  logic [2:0]            hel,
    input  logic                  and_in,
    input  logic                  or_in,
    input  logic [3:0]            shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [3:0]            rem_out,
    output logic [2:0]            flags,
    output logic [2:0]            mode_out
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e               state;
    state_e               state_nxt;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     val;
    logic [4*DIGITS-1:0]  acc;
    logic [4*DIGITS-1:0]  acc_adj;
    logic                 src_neg;
    logic [WIDTH-1:0]     src_val;

    // Per-digit +3 correction applied to the accumulator ahead of each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (acc[4*g +: 4]),
            .q (acc_adj[4*g +: 4])
        );
    end

    // Pick the field that is meaningful for the mode and reduce it to sign + magnitude.
    always_comb begin
        src_neg = 1'b0;
        src_val = '0;
        case (mode)
            MODE_ADD, MODE_SUB, MODE_MUL, MODE_DIV: begin
                // Negating the most negative value wraps back to itself, which
                // reads correctly as the unsigned magnitude 2^(WIDTH-1).
                src_neg = op[WIDTH-1];
                src_val = op[WIDTH-1] ? (~op + 1'b1) : op;
            end
            MODE_CMP: src_val = '0;
            MODE_AND: src_val = WIDTH'(and_in);
            MODE_OR:  src_val = WIDTH'(or_in);
            MODE_SHF: src_val = WIDTH'(shift);
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: accept in IDLE, iterate until the counter is spent, release on handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CONV;
            CONV:    if (cnt == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode directly from state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: capture on accept, shift-add-3 while counting, publish BCD on DONE entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            val      <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            bcd      <= '0;
            rem_out  <= '0;
            flags    <= '0;
            mode_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode_out <= mode;
                        neg      <= src_neg;
                        rem_out  <= (mode == MODE_DIV) ? rem : 4'd0;
                        flags    <= (mode == MODE_CMP) ? hel : 3'd0;
                        val      <= src_val;
                        acc      <= '0;
                        cnt      <= CW'(WIDTH);
                    end
                end
                CONV: begin
                    if (cnt != '0) begin
                        acc <= {acc_adj[4*DIGITS-2:0], val[WIDTH-1]};
                        val <= {val[WIDTH-2:0], 1'b0};
                        cnt <= cnt - 1'b1;
                    end else begin
                        bcd <= acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_result_formatter.sv
module tb_calc_result_formatter;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  mode;
    logic [9:0]  op;
    logic [3:0]  rem;
    logic [2:0]  hel;
    logic        and_in;
    logic        or_in;
    logic [3:0]  shift;
    logic        out_valid;
    logic        out_ready;
    logic        neg;
    logic [11:0] bcd;
    logic [3:0]  rem_out;
    logic [2:0]  flags;
    logic [2:0]  mode_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calc_result_formatter #(.WIDTH(10), .DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .op        (op),
        .rem       (rem),
        .hel       (hel),
        .and_in    (and_in),
        .or_in     (or_in),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .neg       (neg),
        .bcd       (bcd),
        .rem_out   (rem_out),
        .flags     (flags),
        .mode_out  (mode_out)
    );

    // Present one result for a single edge; returns at accept edge + 1.
    task automatic send(input logic [2:0] m, input logic [9:0] o, input logic [3:0] r,
                        input logic [2:0] h, input logic a, input logic ob, input logic [3:0] s);
        mode = m; op = o; rem = r; hel = h; and_in = a; or_in = ob; shift = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_valid: out_valid=%b after %0d cycles, required 1", out_valid, lat);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mode = '0; op = '0; rem = '0; hel = '0; and_in = 0; or_in = 0; shift = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if ({neg, bcd, rem_out, flags, mode_out} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: neg=%b bcd=%h rem_out=%h flags=%b mode_out=%b want all 0",
                     neg, bcd, rem_out, flags, mode_out);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_neg5();
        int lat;
        send(3'b000, 10'h3FB, 4'h0, 3'b000, 0, 0, 4'h0);
        wait_valid(lat);
        checks++; if (lat != 11) begin errors++; $display("FAIL neg5_latency: got %0d want 11", lat); end
        checks++; if (neg !== 1'b1) begin errors++; $display("FAIL neg5_neg: got %b want 1", neg); end
        checks++; if (bcd !== 12'h005) begin errors++; $display("FAIL neg5_bcd: got %h want 005", bcd); end
        checks++; if (mode_out !== 3'b000) begin errors++; $display("FAIL neg5_mode: got %b want 000", mode_out); end
        release_out();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL neg5_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_mul();
        int lat;
        send(3'b010, 10'h200, 4'h0, 3'b000, 0, 0, 4'h0);
        wait_valid(lat);
        checks++; if (neg !== 1'b1 || bcd !== 12'h512) begin
            errors++; $display("FAIL mul_min: neg=%b bcd=%h want 1/512", neg, bcd);
        end
        release_out();
        send(3'b010, 10'h0E1, 4'h0, 3'b000, 0, 0, 4'h0);
        wait_valid(lat);
        checks++; if (neg !== 1'b0 || bcd !== 12'h225) begin
            errors++; $display("FAIL mul_225: neg=%b bcd=%h want 0/225", neg, bcd);
        end
        checks++; if (mode_out !== 3'b010) begin errors++; $display("FAIL mul_mode: got %b want 010", mode_out); end
        release_out();
    endtask

    task automatic test_div_shift();
        int lat;
        send(3'b011, 10'h3FD, 4'h2, 3'b111, 1, 1, 4'hF);
        wait_valid(lat);
        checks++; if (neg !== 1'b1 || bcd !== 12'h003) begin
            errors++; $display("FAIL div_val: neg=%b bcd=%h want 1/003", neg, bcd);
        end
        checks++; if (rem_out !== 4'h2 || flags !== 3'b000) begin
            errors++; $display("FAIL div_side: rem_out=%h flags=%b want 2/000", rem_out, flags);
        end
        release_out();
        send(3'b111, 10'h3FF, 4'h9, 3'b101, 1, 1, 4'hC);
        wait_valid(lat);
        checks++; if (neg !== 1'b0 || bcd !== 12'h012) begin
            errors++; $display("FAIL shf_val: neg=%b bcd=%h want 0/012", neg, bcd);
        end
        checks++; if (rem_out !== 4'h0 || mode_out !== 3'b111) begin
            errors++; $display("FAIL shf_side: rem_out=%h mode_out=%b want 0/111", rem_out, mode_out);
        end
        release_out();
    endtask

    task automatic test_cmp_and();
        int lat;
        send(3'b100, 10'h1FF, 4'h7, 3'b010, 1, 1, 4'h9);
        wait_valid(lat);
        checks++; if (flags !== 3'b010 || bcd !== 12'h000 || neg !== 1'b0) begin
            errors++; $display("FAIL cmp: flags=%b bcd=%h neg=%b want 010/000/0", flags, bcd, neg);
        end
        checks++; if (rem_out !== 4'h0) begin errors++; $display("FAIL cmp_rem: got %h want 0", rem_out); end
        release_out();
        send(3'b101, 10'h3FF, 4'h7, 3'b010, 1, 0, 4'h9);
        wait_valid(lat);
        checks++; if (flags !== 3'b000 || bcd !== 12'h001 || neg !== 1'b0) begin
            errors++; $display("FAIL and: flags=%b bcd=%h neg=%b want 000/001/0", flags, bcd, neg);
        end
        release_out();
        send(3'b110, 10'h3FF, 4'h0, 3'b000, 1, 0, 4'h0);
        wait_valid(lat);
        checks++; if (bcd !== 12'h000 || neg !== 1'b0) begin
            errors++; $display("FAIL or_zero: bcd=%h neg=%b want 000/0", bcd, neg);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        send(3'b000, 10'h07B, 4'h0, 3'b000, 0, 0, 4'h0);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            mode = 3'($urandom); op = 10'($urandom); rem = 4'($urandom);
            hel = 3'($urandom); and_in = 1'($urandom); or_in = 1'($urandom); shift = 4'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || bcd !== 12'h123 || neg !== 1'b0 ||
                mode_out !== 3'b000 || rem_out !== 4'h0 || flags !== 3'b000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b bcd=%h neg=%b mode_out=%b want 1/0/123/0/000",
                         i, out_valid, in_ready, bcd, neg, mode_out);
            end
        end
        in_valid = 1'b0;
        release_out();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== 12'h123) begin
            errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b bcd=%h want 1/0/123", in_ready, out_valid, bcd);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int pulses = 0;
        send(3'b001, 10'h1FF, 4'h0, 3'b000, 0, 0, 4'h0);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== 12'h000) begin
            errors++; $display("FAIL midrst: in_ready=%b out_valid=%b bcd=%h want 1/0/000", in_ready, out_valid, bcd);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_pulse: got %0d out_valid cycles want 0", pulses); end
        send(3'b001, 10'h1FF, 4'h0, 3'b000, 0, 0, 4'h0);
        wait_valid(lat);
        checks++; if (neg !== 1'b0 || bcd !== 12'h511 || mode_out !== 3'b001) begin
            errors++; $display("FAIL after_rst: neg=%b bcd=%h mode_out=%b want 0/511/001", neg, bcd, mode_out);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_neg5();
        test_mul();
        test_div_shift();
        test_cmp_and();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
